peripheral_apb42ahb3_master: RTL and testbench

- APB4 slave to AHB3-Lite master bridge.
- Lets an APB-side requester (debug/DMA-style controller on the peripheral bus) issue single transfers onto the AHB3-Lite fabric that hosts the UART and other peripheral slaves.
- Each APB access becomes exactly one AHB SINGLE transfer; the APB access is stretched with PREADY until the AHB data phase completes.

---
 rtl/peripheral_ahb3_pkg.sv | 30 +++
 rtl/peripheral_apb42ahb3_strb_decode.sv | 57 +++++
 rtl/peripheral_apb42ahb3_master.sv | 148 ++++++++++++++
 tb/tb_peripheral_apb42ahb3_master.sv | 386 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/peripheral_ahb3_pkg.sv
// AHB3-Lite encodings and shared types for the APB4-to-AHB3 master bridge.
package peripheral_ahb3_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HSIZE_BYTE  = 3'b000;
    localparam logic [2:0] HSIZE_HWORD = 3'b001;
    localparam logic [2:0] HSIZE_WORD  = 3'b010;

    localparam logic [2:0] HBURST_SINGLE = 3'b000;

    typedef logic [2:0] fsm_state_t;

    localparam fsm_state_t ST_IDLE  = 3'd0;
    localparam fsm_state_t ST_ADDR  = 3'd1;
    localparam fsm_state_t ST_DATA  = 3'd2;
    localparam fsm_state_t ST_RESP  = 3'd3;
    localparam fsm_state_t ST_DRAIN = 3'd4;

    typedef struct packed {
        logic       legal;
        logic       noop;
        logic [2:0] size;
        logic [1:0] offset;
    } strb_dec_t;

endpackage

// File: rtl/peripheral_apb42ahb3_strb_decode.sv
// Maps an APB strobe pattern and direction to an AHB size and byte offset.
module peripheral_apb42ahb3_strb_decode
    import peripheral_ahb3_pkg::*;
(
    input  logic       pwrite,
    input  logic [3:0] pstrb,
    output strb_dec_t  dec
);

    always_comb begin
        dec = '0;
        unique case (1'b1)
            !pwrite: begin
                dec.legal = 1'b1;
                dec.size  = HSIZE_WORD;
            end
            pwrite && (pstrb == 4'b0000): begin
                dec.noop = 1'b1;
            end
            pwrite && (pstrb == 4'b1111): begin
                dec.legal = 1'b1;
                dec.size  = HSIZE_WORD;
            end
            pwrite && (pstrb == 4'b0011): begin
                dec.legal = 1'b1;
                dec.size  = HSIZE_HWORD;
            end
            pwrite && (pstrb == 4'b1100): begin
                dec.legal  = 1'b1;
                dec.size   = HSIZE_HWORD;
                dec.offset = 2'd2;
            end
            pwrite && (pstrb == 4'b0001): begin
                dec.legal = 1'b1;
                dec.size  = HSIZE_BYTE;
            end
            pwrite && (pstrb == 4'b0010): begin
                dec.legal  = 1'b1;
                dec.size   = HSIZE_BYTE;
                dec.offset = 2'd1;
            end
            pwrite && (pstrb == 4'b0100): begin
                dec.legal  = 1'b1;
                dec.size   = HSIZE_BYTE;
                dec.offset = 2'd2;
            end
            pwrite && (pstrb == 4'b1000): begin
                dec.legal  = 1'b1;
                dec.size   = HSIZE_BYTE;
                dec.offset = 2'd3;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: rtl/peripheral_apb42ahb3_master.sv
// APB4 slave to AHB3-Lite master bridge, one AHB SINGLE per APB access.
// Define PERIPHERAL_APB42AHB3_TIMEOUT_EN to bound the AHB data-phase wait.
module peripheral_apb42ahb3_master
    import peripheral_ahb3_pkg::*;
#(
    parameter int                    PADDR_SIZE     = 8,
    parameter int                    HADDR_SIZE     = 32,
    parameter int                    DATA_SIZE      = 32,
    parameter logic [HADDR_SIZE-1:0] HADDR_BASE     = '0,
    parameter int                    TIMEOUT_CYCLES = 255
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  PSEL,
    input  logic                  PENABLE,
    input  logic                  PWRITE,
    input  logic [PADDR_SIZE-1:0] PADDR,
    input  logic [DATA_SIZE-1:0]  PWDATA,
    input  logic [3:0]            PSTRB,
    input  logic [2:0]            PPROT,
    output logic [DATA_SIZE-1:0]  PRDATA,
    output logic                  PREADY,
    output logic                  PSLVERR,
    output logic [HADDR_SIZE-1:0] HADDR,
    output logic [DATA_SIZE-1:0]  HWDATA,
    input  logic [DATA_SIZE-1:0]  HRDATA,
    output logic                  HWRITE,
    output logic [2:0]            HSIZE,
    output logic [2:0]            HBURST,
    output logic [3:0]            HPROT,
    output logic [1:0]            HTRANS,
    output logic                  HMASTLOCK,
    input  logic                  HREADY,
    input  logic                  HRESP
);

    strb_dec_t             dec;
    fsm_state_t            state;
    logic [HADDR_SIZE-1:0] haddr_nxt;
    logic                  unused_ok;
`ifdef PERIPHERAL_APB42AHB3_TIMEOUT_EN
    logic [31:0]           tmo_cnt;
    logic                  tmo_hit;
`endif

    peripheral_apb42ahb3_strb_decode u_strb_decode (
        .pwrite (PWRITE),
        .pstrb  (PSTRB),
        .dec    (dec)
    );

    assign haddr_nxt = HADDR_BASE
                     | HADDR_SIZE'({PADDR[PADDR_SIZE-1:2], dec.offset});
    assign HBURST    = HBURST_SINGLE;
    assign HMASTLOCK = 1'b0;
    assign unused_ok = ^{PPROT[1], TIMEOUT_CYCLES[0]};

    always_ff @(posedge CLK) begin
        if (RST) begin
            state   <= ST_IDLE;
            HTRANS  <= HTRANS_IDLE;
            HADDR   <= '0;
            HWDATA  <= '0;
            HWRITE  <= 1'b0;
            HSIZE   <= '0;
            HPROT   <= '0;
            PRDATA  <= '0;
            PREADY  <= 1'b0;
            PSLVERR <= 1'b0;
`ifdef PERIPHERAL_APB42AHB3_TIMEOUT_EN
            tmo_cnt <= '0;
            tmo_hit <= 1'b0;
`endif
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (PSEL && !PENABLE) begin
                        if (dec.legal) begin
                            HADDR  <= haddr_nxt;
                            HWRITE <= PWRITE;
                            HSIZE  <= dec.size;
                            HPROT  <= {2'b00, PPROT[0], ~PPROT[2]};
                            HWDATA <= PWDATA;
                            HTRANS <= HTRANS_NONSEQ;
                            state  <= ST_ADDR;
                        end else begin
                            // Empty strobes finish cleanly, bad ones flag an error
                            PREADY  <= 1'b1;
                            PSLVERR <= ~dec.noop;
                            state   <= ST_RESP;
                        end
                    end
                end
                ST_ADDR: begin
                    if (HREADY) begin
                        HTRANS <= HTRANS_IDLE;
                        state  <= ST_DATA;
`ifdef PERIPHERAL_APB42AHB3_TIMEOUT_EN
                        tmo_cnt <= '0;
`endif
                    end
                end
                ST_DATA: begin
                    if (HREADY) begin
                        if (!HWRITE) begin
                            PRDATA <= HRDATA;
                        end
                        PSLVERR <= HRESP;
                        PREADY  <= 1'b1;
                        state   <= ST_RESP;
                    end
`ifdef PERIPHERAL_APB42AHB3_TIMEOUT_EN
                    else if (tmo_cnt == 32'(TIMEOUT_CYCLES - 1)) begin
                        PSLVERR <= 1'b1;
                        PREADY  <= 1'b1;
                        tmo_hit <= 1'b1;
                        state   <= ST_RESP;
                    end else begin
                        tmo_cnt <= tmo_cnt + 32'd1;
                    end
`endif
                end
                ST_RESP: begin
                    PREADY  <= 1'b0;
                    PSLVERR <= 1'b0;
`ifdef PERIPHERAL_APB42AHB3_TIMEOUT_EN
                    // The abandoned data phase must still finish on the bus
                    state   <= tmo_hit ? ST_DRAIN : ST_IDLE;
`else
                    state   <= ST_IDLE;
`endif
                end
`ifdef PERIPHERAL_APB42AHB3_TIMEOUT_EN
                ST_DRAIN: begin
                    if (HREADY) begin
                        tmo_hit <= 1'b0;
                        state   <= ST_IDLE;
                    end
                end
`endif
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_peripheral_apb42ahb3_master.sv
// Randomized bench for the APB4-to-AHB3 bridge against a transaction-level model.
`timescale 1ns/1ps
module tb_peripheral_apb42ahb3_master;

    localparam logic [31:0] BASE = 32'h4000_0000;
    localparam int          TMO  = 4;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        PSEL, PENABLE, PWRITE;
    logic [7:0]  PADDR;
    logic [31:0] PWDATA, PRDATA, HADDR, HWDATA, HRDATA;
    logic [3:0]  PSTRB, HPROT;
    logic [2:0]  PPROT, HSIZE, HBURST;
    logic        PREADY, PSLVERR, HWRITE, HMASTLOCK, HREADY, HRESP;
    logic [1:0]  HTRANS;

    always #5 CLK = ~CLK;

    peripheral_apb42ahb3_master #(
        .PADDR_SIZE     (8),
        .HADDR_SIZE     (32),
        .DATA_SIZE      (32),
        .HADDR_BASE     (BASE),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .PSEL      (PSEL),
        .PENABLE   (PENABLE),
        .PWRITE    (PWRITE),
        .PADDR     (PADDR),
        .PWDATA    (PWDATA),
        .PSTRB     (PSTRB),
        .PPROT     (PPROT),
        .PRDATA    (PRDATA),
        .PREADY    (PREADY),
        .PSLVERR   (PSLVERR),
        .HADDR     (HADDR),
        .HWDATA    (HWDATA),
        .HRDATA    (HRDATA),
        .HWRITE    (HWRITE),
        .HSIZE     (HSIZE),
        .HBURST    (HBURST),
        .HPROT     (HPROT),
        .HTRANS    (HTRANS),
        .HMASTLOCK (HMASTLOCK),
        .HREADY    (HREADY),
        .HRESP     (HRESP)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc_no   = 0;
    int t0_cyc   = 0;
    int nonseq_cnt = 0;
    int seen_pready_cyc = -1;
    logic [31:0] seen_haddr, seen_hwdata, seen_prdata;
    logic [2:0]  seen_hsize;
    logic        seen_pslverr;

    logic        chk_en = 1'b0;
    logic        chk_addr = 1'b0;
    logic        chk_wdata = 1'b0;
    logic [1:0]  exp_htrans = 2'b00;
    logic        exp_pready = 1'b0;
    logic        exp_pslverr = 1'b0;
    logic [31:0] model_prdata = 32'h0;
    logic [31:0] exp_haddr, exp_hwdata;
    logic [2:0]  exp_hsize;
    logic        exp_hwrite;
    logic [3:0]  exp_hprot;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)",
                     name, act, exp, cyc_no);
        end
    endtask

    always @(posedge CLK) cyc_no <= cyc_no + 1;

    always @(negedge CLK) begin
        if (HTRANS == 2'b10) begin
            nonseq_cnt++;
            seen_haddr = HADDR;
            seen_hsize = HSIZE;
        end
        if (PREADY) begin
            seen_pready_cyc = cyc_no - t0_cyc;
            seen_pslverr    = PSLVERR;
            seen_prdata     = PRDATA;
        end
        if (chk_wdata) seen_hwdata = HWDATA;
        if (chk_en) begin
            check("htrans", 64'(HTRANS), 64'(exp_htrans));
            check("pready", 64'(PREADY), 64'(exp_pready));
            check("pslverr", 64'(PSLVERR), 64'(exp_pslverr));
            check("prdata", 64'(PRDATA), 64'(model_prdata));
            check("hburst_lock", 64'({HBURST, HMASTLOCK}), 64'(0));
            if (chk_addr) begin
                check("haddr", 64'(HADDR), 64'(exp_haddr));
                check("hsize", 64'(HSIZE), 64'(exp_hsize));
                check("hwrite", 64'(HWRITE), 64'(exp_hwrite));
                check("hprot", 64'(HPROT), 64'(exp_hprot));
            end
            if (chk_wdata) check("hwdata", 64'(HWDATA), 64'(exp_hwdata));
        end
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic set_idle_exp();
        exp_htrans  = 2'b00;
        exp_pready  = 1'b0;
        exp_pslverr = 1'b0;
        chk_addr    = 1'b0;
        chk_wdata   = 1'b0;
    endtask

    // Strobe rules: reads are words; writes by popcount and position
    function automatic void model_decode(input logic wr, input logic [3:0] s,
                                         output bit go, output bit bad,
                                         output logic [2:0] sz,
                                         output logic [1:0] off);
        int ones;
        ones = $countones(s);
        go = 0;
        bad = 0;
        sz = 3'd0;
        off = 2'd0;
        if (!wr) begin
            go = 1;
            sz = 3'd2;
        end else if (ones == 0) begin
            go = 0;
        end else if (ones == 4) begin
            go = 1;
            sz = 3'd2;
        end else if (ones == 2 && (s == 4'b0011 || s == 4'b1100)) begin
            go = 1;
            sz = 3'd1;
            off = s[2] ? 2'd2 : 2'd0;
        end else if (ones == 1) begin
            go = 1;
            sz = 3'd0;
            for (int i = 0; i < 4; i++) if (s[i]) off = i[1:0];
        end else begin
            bad = 1;
        end
    endfunction

    task automatic idle_cycle();
        PSEL = 1'b0;
        PENABLE = 1'b0;
        HREADY = 1'($urandom);
        HRESP = 1'b0;
        HRDATA = $urandom;
        set_idle_exp();
        step();
    endtask

    task automatic run_txn(input logic wr, input logic [7:0] pa,
                           input logic [31:0] wd, input logic [3:0] st,
                           input logic [2:0] pp, input int aw, input int dw,
                           input bit er, input logic [31:0] rd);
        bit go, bad;
        logic [2:0] sz;
        logic [1:0] off;
        model_decode(wr, st, go, bad, sz, off);
        PSEL = 1'b1;
        PENABLE = 1'b0;
        PWRITE = wr;
        PADDR = pa;
        PWDATA = wd;
        PSTRB = st;
        PPROT = pp;
        HREADY = 1'b1;
        HRESP = 1'b0;
        HRDATA = $urandom;
        set_idle_exp();
        t0_cyc = cyc_no;
        step();
        PENABLE = 1'b1;
        if (!go) begin
            exp_pready = 1'b1;
            exp_pslverr = bad;
            step();
            return;
        end
        exp_htrans = 2'b10;
        chk_addr = 1'b1;
        exp_haddr = BASE | {24'h0, pa[7:2], off};
        exp_hsize = sz;
        exp_hwrite = wr;
        exp_hprot = {2'b00, pp[0], ~pp[2]};
        for (int i = 0; i <= aw; i++) begin
            PSEL = ($urandom % 6) != 0;
            HREADY = (i == aw);
            HRDATA = $urandom;
            step();
        end
        exp_htrans = 2'b00;
        chk_addr = 1'b0;
        chk_wdata = wr;
        exp_hwdata = wd;
        for (int j = 0; j <= dw; j++) begin
            PSEL = ($urandom % 6) != 0;
            HREADY = (j == dw);
            HRESP = er && (j >= dw - 1);
            HRDATA = (j == dw) ? rd : $urandom;
            step();
        end
        chk_wdata = 1'b0;
        exp_pready = 1'b1;
        exp_pslverr = er;
        if (!wr) model_prdata = rd;
        PSEL = 1'b1;
        HREADY = 1'b1;
        HRESP = 1'b0;
        HRDATA = $urandom;
        step();
    endtask

    task automatic pre_directed(output int ns0);
        ns0 = nonseq_cnt;
        seen_pready_cyc = -1;
        seen_pslverr = 1'bx;
    endtask

    initial begin
        int ns0;
        logic wr;
        logic [3:0] st;
        int aw, dw, gap;
        bit er;

        PSEL = 0; PENABLE = 0; PWRITE = 0; PADDR = 0; PWDATA = 0;
        PSTRB = 0; PPROT = 0; HRDATA = 0; HREADY = 1; HRESP = 0;
        repeat (3) step();
        check("reset_ahb", 64'({HTRANS, HADDR, HWRITE, HSIZE, HPROT}), 64'(0));
        check("reset_data", {HWDATA, PRDATA}, 64'(0));
        check("reset_apb", 64'({PREADY, PSLVERR}), 64'(0));
        RST = 1'b0;
        set_idle_exp();
        chk_en = 1'b1;
        step();

        pre_directed(ns0);
        run_txn(1'b1, 8'h14, 32'hDEADBEEF, 4'b1111, 3'b000, 0, 0, 0, 32'h0);
        check("word_nonseq", 64'(nonseq_cnt - ns0), 64'(1));
        check("word_haddr", 64'(seen_haddr), 64'h4000_0014);
        check("word_hsize", 64'(seen_hsize), 64'(3'b010));
        check("word_hwdata", 64'(seen_hwdata), 64'hDEADBEEF);
        check("word_latency", 64'(seen_pready_cyc), 64'(3));
        check("word_pslverr", 64'(seen_pslverr), 64'(0));

        pre_directed(ns0);
        run_txn(1'b0, 8'h08, 32'h0, 4'b0000, 3'b000, 0, 3, 0, 32'h12345678);
        check("rd3_latency", 64'(seen_pready_cyc), 64'(6));
        check("rd3_prdata", 64'(seen_prdata), 64'h12345678);
        check("rd3_haddr", 64'(seen_haddr), 64'h4000_0008);

        pre_directed(ns0);
        run_txn(1'b1, 8'h20, 32'hA1B2C3D4, 4'b1100, 3'b101, 0, 0, 0, 32'h0);
        check("hw_haddr", 64'(seen_haddr), 64'h4000_0022);
        check("hw_hsize", 64'(seen_hsize), 64'(3'b001));

        pre_directed(ns0);
        run_txn(1'b1, 8'h20, 32'h00770000, 4'b0100, 3'b000, 1, 0, 0, 32'h0);
        check("byte_haddr", 64'(seen_haddr), 64'h4000_0022);
        check("byte_hsize", 64'(seen_hsize), 64'(3'b000));

        pre_directed(ns0);
        run_txn(1'b1, 8'h24, 32'h1, 4'b0101, 3'b000, 0, 0, 0, 32'h0);
        check("illegal_nonseq", 64'(nonseq_cnt - ns0), 64'(0));
        check("illegal_latency", 64'(seen_pready_cyc), 64'(1));
        check("illegal_pslverr", 64'(seen_pslverr), 64'(1));

        pre_directed(ns0);
        run_txn(1'b1, 8'h28, 32'h2, 4'b0000, 3'b000, 0, 0, 0, 32'h0);
        check("noop_nonseq", 64'(nonseq_cnt - ns0), 64'(0));
        check("noop_pslverr", 64'(seen_pslverr), 64'(0));

        pre_directed(ns0);
        run_txn(1'b0, 8'h40, 32'h0, 4'b0000, 3'b000, 0, 1, 1, 32'hCAFEF00D);
        check("err_pslverr", 64'(seen_pslverr), 64'(1));
        pre_directed(ns0);
        run_txn(1'b0, 8'h44, 32'h0, 4'b0000, 3'b000, 1, 0, 0, 32'h0BADF00D);
        check("after_err_pslverr", 64'(seen_pslverr), 64'(0));
        check("after_err_prdata", 64'(seen_prdata), 64'h0BADF00D);

        for (int n = 0; n < 300; n++) begin
            wr = 1'($urandom);
            st = 4'($urandom);
            aw = $urandom_range(0, 2);
            dw = $urandom_range(0, 3);
            er = (dw >= 1) && ($urandom % 4 == 0);
            gap = $urandom_range(0, 2);
            run_txn(wr, 8'($urandom), $urandom, st, 3'($urandom),
                    aw, dw, er, $urandom);
            for (int g = 0; g < gap; g++) idle_cycle();
        end

        // Reset while the address phase is stalled
        chk_en = 1'b0;
        PSEL = 1; PENABLE = 0; PWRITE = 1; PADDR = 8'h10; PSTRB = 4'hF;
        HREADY = 1;
        step();
        check("pre_rst_nonseq", 64'(HTRANS), 64'(2'b10));
        PENABLE = 1; HREADY = 0; RST = 1;
        step();
        check("rst_addr_htrans", 64'(HTRANS), 64'(0));
        check("rst_addr_pready", 64'(PREADY), 64'(0));
        RST = 0; PSEL = 0; PENABLE = 0; HREADY = 1;
        step();

        // Reset in a data phase that would otherwise complete
        PSEL = 1; PENABLE = 0; PWRITE = 0; PADDR = 8'h18; HREADY = 1;
        step();
        PENABLE = 1;
        step();
        HRDATA = 32'h55AA55AA; RST = 1;
        step();
        check("rst_data_pready", 64'(PREADY), 64'(0));
        check("rst_data_htrans", 64'(HTRANS), 64'(0));
        check("rst_data_prdata", 64'(PRDATA), 64'(0));
        model_prdata = 32'h0;
        RST = 0; PSEL = 0; PENABLE = 0;
        set_idle_exp();
        step();
        chk_en = 1'b1;
        run_txn(1'b0, 8'h50, 32'h0, 4'h0, 3'b001, 0, 0, 0, 32'hA5A55A5A);
        idle_cycle();

`ifdef PERIPHERAL_APB42AHB3_TIMEOUT_EN
        chk_en = 1'b0;
        ns0 = nonseq_cnt;
        PSEL = 1; PENABLE = 0; PWRITE = 0; PADDR = 8'h30; PSTRB = 0;
        HREADY = 1; HRESP = 0;
        step();
        PENABLE = 1;
        step();
        HREADY = 0;
        for (int i = 0; i < TMO; i++) begin
            check("tmo_wait_pready", 64'(PREADY), 64'(0));
            step();
        end
        check("tmo_pready", 64'(PREADY), 64'(1));
        check("tmo_pslverr", 64'(PSLVERR), 64'(1));
        check("tmo_prdata", 64'(PRDATA), 64'(model_prdata));
        PENABLE = 0;
        step();
        check("drain_pready", 64'(PREADY), 64'(0));
        step();
        check("drain_htrans_a", 64'(HTRANS), 64'(0));
        step();
        check("drain_htrans_b", 64'(HTRANS), 64'(0));
        HREADY = 1;
        step();
        check("drain_htrans_c", 64'(HTRANS), 64'(0));
        PSEL = 0;
        step();
        check("drain_nonseq", 64'(nonseq_cnt - ns0), 64'(1));
        set_idle_exp();
        chk_en = 1'b1;
        pre_directed(ns0);
        run_txn(1'b1, 8'h34, 32'h13572468, 4'b0011, 3'b000, 0, 1, 0, 32'h0);
        check("post_tmo_pslverr", 64'(seen_pslverr), 64'(0));
        check("post_tmo_nonseq", 64'(nonseq_cnt - ns0), 64'(1));
`endif

        idle_cycle();
        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
